// File: rtl/tt_um_weight_enum.sv
// Weight-to-pattern enumerator: takes a one-hot Hamming weight code and streams
// every 4-bit pattern of that weight, one beat per valid/ready handshake.
module tt_um_weight_enum #(
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       v,
    input  logic       w,
    input  logic       x,
    input  logic       y,
    input  logic       z,
    output logic [3:0] pat,
    output logic       pat_valid,
    input  logic       pat_ready,
    output logic       pat_last,
    output logic [2:0] idx,
    output logic       err
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_next;
    logic [2:0] wt;
    logic [2:0] new_wt;
    logic [2:0] code_ones;
    logic       legal;
    logic       accept;
    logic       xfer;
    logic [3:0] first_pat;
    logic [3:0] next_pat;

    function automatic logic [2:0] ones4(input logic [3:0] p);
        return 3'(p[0]) + 3'(p[1]) + 3'(p[2]) + 3'(p[3]);
    endfunction

    // Index of the final beat for each weight: sequence lengths 1,4,6,4,1.
    function automatic logic [2:0] last_idx(input logic [2:0] k);
        case (k)
            3'd1, 3'd3: return 3'd3;
            3'd2:       return 3'd5;
            default:    return 3'd0;
        endcase
    endfunction

    assign code_ones = 3'(v) + 3'(w) + 3'(x) + 3'(y) + 3'(z);
    assign legal     = (code_ones == 3'd1);
    assign req_ready = reset && ena && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign xfer      = (state == RUN) && pat_valid && pat_ready && ena;

    always_comb begin
        new_wt = 3'd4;
        if (v)      new_wt = 3'd0;
        else if (w) new_wt = 3'd1;
        else if (x) new_wt = 3'd2;
        else if (y) new_wt = 3'd3;
    end

    // Candidate scans: the loop order makes the value nearest the start win.
    always_comb begin
        first_pat = 4'd0;
        next_pat  = pat;
        if (DESCEND) begin
            for (int i = 0; i < 16; i++) begin
                if (ones4(4'(i)) == new_wt) first_pat = 4'(i);
                if (ones4(4'(i)) == wt && 4'(i) < pat) next_pat = 4'(i);
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (ones4(4'(i)) == new_wt) first_pat = 4'(i);
                if (ones4(4'(i)) == wt && 4'(i) > pat) next_pat = 4'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && legal) state_next = RUN;
            RUN:     if (xfer && pat_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wt        <= 3'd0;
            pat       <= 4'd0;
            pat_valid <= 1'b0;
            pat_last  <= 1'b0;
            idx       <= 3'd0;
            err       <= 1'b0;
        end else if (ena) begin
            err <= accept && !legal;
            if (accept && legal) begin
                wt        <= new_wt;
                pat       <= first_pat;
                idx       <= 3'd0;
                pat_valid <= 1'b1;
                pat_last  <= (last_idx(new_wt) == 3'd0);
            end else if (xfer) begin
                if (pat_last) begin
                    pat_valid <= 1'b0;
                    pat_last  <= 1'b0;
                end else begin
                    pat      <= next_pat;
                    idx      <= idx + 3'd1;
                    pat_last <= (idx + 3'd1 == last_idx(wt));
                end
            end
        end
    end

endmodule

// File: tb/tb_tt_um_weight_enum.sv
// Randomized bench for tt_um_weight_enum: an ascending and a descending
// instance share stimulus and are checked against popcount-derived sequences.
module tb_tt_um_weight_enum;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ena = 1'b1;
    logic       req_valid = 1'b0;
    logic       v = 1'b0, w = 1'b0, x = 1'b0, y = 1'b0, z = 1'b0;
    logic       pat_ready = 1'b0;
    logic       req_ready_a, pat_valid_a, pat_last_a, err_a;
    logic       req_ready_d, pat_valid_d, pat_last_d, err_d;
    logic [3:0] pat_a, pat_d;
    logic [2:0] idx_a, idx_d;

    int errors = 0;
    int checks = 0;
    int seen_a[16];
    int seen_d[16];

    always #5 clk = ~clk;

    tt_um_weight_enum #(.DESCEND(1'b0)) dut_a (
        .clk(clk), .reset(reset), .ena(ena), .req_valid(req_valid), .req_ready(req_ready_a),
        .v(v), .w(w), .x(x), .y(y), .z(z), .pat(pat_a), .pat_valid(pat_valid_a),
        .pat_ready(pat_ready), .pat_last(pat_last_a), .idx(idx_a), .err(err_a)
    );

    tt_um_weight_enum #(.DESCEND(1'b1)) dut_d (
        .clk(clk), .reset(reset), .ena(ena), .req_valid(req_valid), .req_ready(req_ready_d),
        .v(v), .w(w), .x(x), .y(y), .z(z), .pat(pat_d), .pat_valid(pat_valid_d),
        .pat_ready(pat_ready), .pat_last(pat_last_d), .idx(idx_d), .err(err_d)
    );

    task automatic set_code(input logic [4:0] c);
        {v, w, x, y, z} = c;
    endtask

    // Request one weight and follow the whole sequence on both instances.
    task automatic run_seq(input int wt, input bit bp);
        logic [3:0] exp_a[$];
        logic [3:0] exp_d[$];
        logic [3:0] prev_a, prev_d;
        logic [2:0] prev_ia, prev_id;
        bit         stalled;
        int         k;
        int         n;
        for (int i = 0; i < 16; i++)
            if ($countones(i[3:0]) == wt) begin
                exp_a.push_back(4'(i));
                exp_d.push_front(4'(i));
            end
        n = exp_a.size();
        k = 0;
        stalled = 1'b0;
        prev_a = '0; prev_d = '0; prev_ia = '0; prev_id = '0;
        @(negedge clk);
        ena = 1'b1;
        pat_ready = 1'b0;
        req_valid = 1'b1;
        set_code(5'b10000 >> wt);
        checks++;
        if (req_ready_a !== 1'b1 || req_ready_d !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle w%0d: got %b/%b want 1", wt, req_ready_a, req_ready_d);
        end
        for (int cyc = 0; cyc < 300 && k < n; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0;
            set_code(5'b00000);
            if (cyc == 0) begin
                checks++;
                if (pat_valid_a !== 1'b1 || pat_valid_d !== 1'b1) begin
                    errors++;
                    $display("FAIL latency w%0d: pat_valid %b/%b want 1", wt, pat_valid_a, pat_valid_d);
                end
            end
            if (stalled) begin
                checks++;
                if (pat_a !== prev_a || idx_a !== prev_ia || pat_d !== prev_d || idx_d !== prev_id) begin
                    errors++;
                    $display("FAIL stall_hold w%0d: got %0d/%0d idx %0d/%0d want %0d/%0d idx %0d/%0d",
                             wt, pat_a, pat_d, idx_a, idx_d, prev_a, prev_d, prev_ia, prev_id);
                end
            end
            pat_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            ena       = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            prev_a = pat_a; prev_d = pat_d; prev_ia = idx_a; prev_id = idx_d;
            stalled = pat_valid_a && !(pat_ready && ena);
            if (pat_valid_a && pat_ready && ena) begin
                checks++;
                if (pat_a !== exp_a[k] || idx_a !== 3'(k) || pat_last_a !== (k == n - 1) || err_a !== 1'b0) begin
                    errors++;
                    $display("FAIL beat_asc w%0d k%0d: got pat %0d idx %0d last %b err %b want pat %0d idx %0d last %b",
                             wt, k, pat_a, idx_a, pat_last_a, err_a, exp_a[k], k, k == n - 1);
                end
                checks++;
                if (pat_valid_d !== 1'b1 || pat_d !== exp_d[k] || idx_d !== 3'(k) || pat_last_d !== (k == n - 1)) begin
                    errors++;
                    $display("FAIL beat_desc w%0d k%0d: got v %b pat %0d idx %0d last %b want pat %0d idx %0d last %b",
                             wt, k, pat_valid_d, pat_d, idx_d, pat_last_d, exp_d[k], k, k == n - 1);
                end
                seen_a[pat_a]++;
                seen_d[pat_d]++;
                k++;
            end
        end
        checks++;
        if (k != n) begin
            errors++;
            $display("FAIL timeout w%0d: beats %0d want %0d", wt, k, n);
        end else begin
            @(negedge clk);
            ena = 1'b1;
            pat_ready = 1'b0;
            #1;
            if (pat_valid_a !== 1'b0 || pat_last_a !== 1'b0 || req_ready_a !== 1'b1 ||
                pat_valid_d !== 1'b0 || req_ready_d !== 1'b1) begin
                errors++;
                $display("FAIL back_idle w%0d: valid %b/%b last %b ready %b/%b want 0/0 0 1/1",
                         wt, pat_valid_a, pat_valid_d, pat_last_a, req_ready_a, req_ready_d);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (pat_a !== 4'd0 || pat_valid_a !== 1'b0 || pat_last_a !== 1'b0 || idx_a !== 3'd0 ||
            err_a !== 1'b0 || req_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pat %0d valid %b last %b idx %0d err %b ready %b want all 0",
                     pat_a, pat_valid_a, pat_last_a, idx_a, err_a, req_ready_a);
        end
        @(negedge clk);
        reset = 1'b1;
        // Start weight x, move two beats, then reset mid-sequence.
        @(negedge clk);
        req_valid = 1'b1; set_code(5'b00100); pat_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; set_code(5'b00000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (pat_valid_a !== 1'b1 || idx_a !== 3'd2 || pat_a !== 4'd6) begin
            errors++;
            $display("FAIL pre_reset_run: valid %b idx %0d pat %0d want 1 2 6", pat_valid_a, idx_a, pat_a);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (pat_a !== 4'd0 || pat_valid_a !== 1'b0 || idx_a !== 3'd0 || req_ready_a !== 1'b0 ||
            pat_d !== 4'd0 || pat_valid_d !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pat %0d/%0d valid %b/%b idx %0d ready %b want 0",
                     pat_a, pat_d, pat_valid_a, pat_valid_d, idx_a, req_ready_a);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req_ready_a !== 1'b1 || pat_valid_a !== 1'b0 || pat_valid_d !== 1'b0) begin
                errors++;
                $display("FAIL post_reset c%0d: ready %b valid %b/%b want 1 0 0",
                         i, req_ready_a, pat_valid_a, pat_valid_d);
            end
        end
    endtask

    task automatic test_weight_x;
        run_seq(2, 1'b0);
    endtask

    task automatic test_single_and_four;
        run_seq(0, 1'b0);
        run_seq(4, 1'b0);
        run_seq(1, 1'b0);
        run_seq(3, 1'b0);
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 4; r++) run_seq(3, 1'b1);
        for (int r = 0; r < 4; r++) run_seq(int'($urandom_range(0, 4)), 1'b1);
    endtask

    task automatic test_illegal;
        logic [4:0] bad[2];
        bad[0] = 5'b11000;
        bad[1] = 5'b00000;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            ena = 1'b1; pat_ready = 1'b1;
            req_valid = 1'b1; set_code(bad[b]);
            @(negedge clk);
            req_valid = 1'b0; set_code(5'b00000);
            checks++;
            if (err_a !== 1'b1 || err_d !== 1'b1 || pat_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
                errors++;
                $display("FAIL illegal_pulse code%b: err %b/%b valid %b ready %b want 1 1 0 1",
                         bad[b], err_a, err_d, pat_valid_a, req_ready_a);
            end
            @(negedge clk);
            checks++;
            if (err_a !== 1'b0 || pat_valid_a !== 1'b0) begin
                errors++;
                $display("FAIL illegal_clear code%b: err %b valid %b want 0 0", bad[b], err_a, pat_valid_a);
            end
        end
        run_seq(2, 1'b1);
    endtask

    task automatic test_exhaustive;
        for (int i = 0; i < 16; i++) begin
            seen_a[i] = 0;
            seen_d[i] = 0;
        end
        for (int wt = 0; wt < 5; wt++) run_seq(wt, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (seen_a[i] != 1 || seen_d[i] != 1) begin
                errors++;
                $display("FAIL exhaustive val%0d: count %0d/%0d want 1", i, seen_a[i], seen_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_weight_x();
        test_single_and_four();
        test_backpressure();
        test_illegal();
        test_exhaustive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
